// File: rtl/ibex_instr_aligner.sv
// rtl/ibex_instr_aligner.sv - splits fetch words into 16/32-bit instructions for the decoder
// Optional fetch error tracking is enabled by defining IBEX_ALIGNER_FETCH_ERR_EN.
module ibex_instr_aligner #(
  parameter logic [31:0] ResetAddr = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_is_compressed_o,
  output logic        instr_fetch_err_o,
  output logic        instr_fetch_err_plus2_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i
);

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HALF    = 2'd1,
    SKIP    = 2'd2
  } state_e;

  state_e      state_q;
  logic [15:0] res_q;
  logic [31:0] res_addr_q;
  logic        res_is_32;
  logic        word_is_32;
  logic        instr_accept;
  logic        err_in;
  logic        res_err;

  logic unused_inputs;
  assign unused_inputs = ^{branch_addr_i[0], fetch_err_i};

`ifdef IBEX_ALIGNER_FETCH_ERR_EN
  logic res_err_q;
  assign err_in  = fetch_err_i;
  assign res_err = res_err_q;
`else
  assign err_in  = 1'b0;
  assign res_err = 1'b0;
`endif

  assign res_is_32  = (res_q[1:0] == 2'b11);
  assign word_is_32 = (fetch_rdata_i[1:0] == 2'b11);

  always_comb begin
    instr_valid_o           = 1'b0;
    fetch_ready_o           = 1'b0;
    instr_rdata_o           = fetch_rdata_i;
    instr_addr_o            = fetch_addr_i;
    instr_fetch_err_o       = 1'b0;
    instr_fetch_err_plus2_o = 1'b0;
    case (state_q)
      ALIGNED: begin
        instr_valid_o     = fetch_valid_i;
        fetch_ready_o     = instr_ready_i;
        instr_rdata_o     = word_is_32 ? fetch_rdata_i : {16'h0, fetch_rdata_i[15:0]};
        instr_fetch_err_o = err_in;
      end
      HALF: begin
        instr_addr_o = res_addr_q;
        if (!res_is_32) begin
          // Compressed residue is self-contained; the pending word stays put.
          instr_valid_o     = 1'b1;
          instr_rdata_o     = {16'h0, res_q};
          instr_fetch_err_o = res_err;
        end else begin
          instr_valid_o           = fetch_valid_i;
          fetch_ready_o           = instr_ready_i;
          instr_rdata_o           = {fetch_rdata_i[15:0], res_q};
          instr_fetch_err_o       = res_err | err_in;
          instr_fetch_err_plus2_o = !res_err && err_in;
        end
      end
      SKIP: begin
        fetch_ready_o = 1'b1;
      end
      default: ;
    endcase
    if (branch_i) begin
      instr_valid_o = 1'b0;
      fetch_ready_o = 1'b0;
    end
  end

  assign instr_is_compressed_o = (instr_rdata_o[1:0] != 2'b11);
  assign instr_accept          = instr_valid_o && instr_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ALIGNED;
      res_q      <= 16'h0;
      res_addr_q <= ResetAddr;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
      res_err_q  <= 1'b0;
`endif
    end else if (branch_i) begin
      state_q    <= branch_addr_i[1] ? SKIP : ALIGNED;
      res_addr_q <= {branch_addr_i[31:1], 1'b0};
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
      res_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ALIGNED: begin
          if (instr_accept && !word_is_32) begin
            state_q    <= HALF;
            res_q      <= fetch_rdata_i[31:16];
            res_addr_q <= fetch_addr_i + 32'd2;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
            res_err_q  <= fetch_err_i;
`endif
          end
        end
        HALF: begin
          if (instr_accept) begin
            if (!res_is_32) begin
              state_q <= ALIGNED;
            end else begin
              res_q      <= fetch_rdata_i[31:16];
              res_addr_q <= fetch_addr_i + 32'd2;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
              res_err_q  <= fetch_err_i;
`endif
            end
          end
        end
        SKIP: begin
          // The lower half precedes the branch target and is dropped.
          if (fetch_valid_i) begin
            state_q    <= HALF;
            res_q      <= fetch_rdata_i[31:16];
            res_addr_q <= fetch_addr_i + 32'd2;
`ifdef IBEX_ALIGNER_FETCH_ERR_EN
            res_err_q  <= fetch_err_i;
`endif
          end
        end
        default: state_q <= ALIGNED;
      endcase
    end
  end

endmodule
